// File: rtl/sync_fifo_reader.sv
// ============================================================================
// Module      : sync_fifo_reader
// Description : Drains a registered-read synchronous FIFO into a valid/ready
//               stream through a 2-entry head/skid output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_read_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i
);

    localparam logic [2:0] c_BUF_DEPTH = 3'd2;

    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;

    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_tail_is_head;

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = head_q;
    assign w_pop   = valid_o & ready_i;

    // Buffered words plus the word still in flight must never exceed the
    // two entries; a pop in this cycle frees one slot for a new read.
    assign w_level     = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_read_o = ~rst_i & ~fifo_empty_i & ((w_level < c_BUF_DEPTH) | w_pop);

    // The returning word lands in the head slot only if the head is (or is
    // about to become) free; otherwise it waits in the skid slot.
    assign w_tail_is_head = (occ_q == 2'd0) | ((occ_q == 2'd1) & w_pop);

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;

        if (w_pop) begin
            head_d = skid_q;
        end

        if (inflight_q) begin
            if (w_tail_is_head) begin
                head_d = fifo_rd_data_i;
            end else begin
                skid_d = fifo_rd_data_i;
            end
        end

        if (inflight_q && !w_pop) begin
            occ_d = occ_q + 2'd1;
        end else if (w_pop && !inflight_q) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_read_o;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_reader.sv
// ============================================================================
// Module      : tb_sync_fifo_reader
// Description : Self-checking bench for sync_fifo_reader with a queue-based
//               FIFO environment and a queue-based buffer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_reader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_read;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready = 1'b0;

    sync_fifo_reader #(.DATA_WIDTH(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_data_i (fifo_rd_data),
        .fifo_read_o    (fifo_read),
        .valid_o        (valid),
        .data_o         (data),
        .ready_i        (ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fq[$];   // FIFO contents
    logic [DW-1:0] mq[$];   // expected output buffer contents, head first
    bit            minfl = 1'b0;
    logic [DW-1:0] acc[$];  // words actually accepted by the consumer
    logic [DW-1:0] expw[$];
    int            nreads;
    int            nvalids;
    logic          snap_read;
    logic [DW-1:0] snap_data;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic check_stream(input string tag, input logic [DW-1:0] exp[$]);
        check({tag, "_count"}, DW'(acc.size()), DW'(exp.size()));
        for (int i = 0; i < exp.size() && i < acc.size(); i++) begin
            check({tag, "_word"}, acc[i], exp[i]);
        end
    endtask

    // One clock: check at the falling edge, advance model and FIFO after the rising edge.
    task automatic cycle();
        bit            s_rst;
        bit            ev;
        bit            epop;
        bit            eread;
        bit            a_read;
        @(negedge clk);
        s_rst = rst;
        ev    = 1'b0;
        epop  = 1'b0;
        eread = 1'b0;
        if (s_rst) begin
            check("rst_valid", DW'(valid), 0);
            check("rst_read", DW'(fifo_read), 0);
            check("rst_data", data, 0);
        end else begin
            ev    = (mq.size() != 0);
            epop  = ev && ready;
            eread = !fifo_empty && (((mq.size() + int'(minfl)) < 2) || epop);
            check("valid", DW'(valid), DW'(ev));
            check("read", DW'(fifo_read), DW'(eread));
            if (ev) check("data", data, mq[0]);
        end
        check("no_read_when_empty", DW'(fifo_read && fifo_empty), 0);
        a_read    = fifo_read;
        snap_read = fifo_read;
        snap_data = data;
        nreads   += int'(fifo_read);
        nvalids  += int'(valid);
        if (valid && ready && !s_rst) acc.push_back(data);
        @(posedge clk);
        #1;
        if (s_rst) begin
            mq.delete();
            minfl = 1'b0;
        end else begin
            if (epop) void'(mq.pop_front());
            if (minfl) mq.push_back(fifo_rd_data);
            minfl = eread;
        end
        if (a_read && fq.size() != 0) fifo_rd_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        // Reset held with three words waiting in the FIFO
        push(32'hDEAD_0001); push(32'hDEAD_0002); push(32'hDEAD_0003);
        for (int k = 0; k < 3; k++) cycle();
        fq.delete();
        fifo_empty = 1'b1;
        check("rst_fifo_untouched", 0, 0 + 0 * int'(fifo_read));
        rst = 1'b0;

        // Streaming 1..8 with ready held high
        acc.delete(); expw.delete(); nreads = 0;
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin push(DW'(i)); expw.push_back(DW'(i)); end
        for (int k = 0; k < 12; k++) cycle();
        check("stream_reads", DW'(nreads), 8);
        check_stream("stream", expw);

        // Backpressure: accept A0, stall 5 cycles, resume
        acc.delete(); expw.delete();
        for (int i = 0; i < 6; i++) begin push(32'hA0 + DW'(i)); expw.push_back(32'hA0 + DW'(i)); end
        for (int k = 0; k < 20; k++) begin
            ready = (k < 3 || k >= 8);
            cycle();
            if (k == 6) begin
                check("stall_read", DW'(snap_read), 0);
                check("stall_data", snap_data, 32'hA1);
            end
        end
        check_stream("bp", expw);

        // Single word
        acc.delete(); expw.delete(); nreads = 0; nvalids = 0;
        ready = 1'b1;
        push(32'h55); expw.push_back(32'h55);
        for (int k = 0; k < 6; k++) cycle();
        check("single_reads", DW'(nreads), 1);
        check("single_valids", DW'(nvalids), 1);
        check_stream("single", expw);

        // Randomized traffic and stalls, then drain
        acc.delete(); expw.delete();
        for (int k = 0; k < 300; k++) begin
            logic [DW-1:0] w;
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                w = $urandom;
                push(w);
                expw.push_back(w);
            end
            cycle();
        end
        ready = 1'b1;
        for (int k = 0; k < 400 && (fq.size() != 0 || mq.size() != 0 || minfl); k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        check_stream("random", expw);

        // Reset the cycle after a read: that word is lost
        acc.delete(); expw.delete();
        for (int i = 0; i < 4; i++) push(32'hB0 + DW'(i));
        expw.push_back(32'hB1); expw.push_back(32'hB2); expw.push_back(32'hB3);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        check_stream("midrst", expw);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
